// File: rtl/udma_rx_packer_if.sv
// Beat channel between the RX packer and the uDMA linear RX channel.
// master drives valid/data/datasize, slave returns ready.
interface udma_rx_packer_if;
  logic        valid;
  logic [31:0] data;
  logic [1:0]  datasize;  // 0 = byte, 1 = halfword, 2 = word
  logic        ready;

  modport master (output valid, output data, output datasize, input ready);
  modport slave  (input valid, input data, input datasize, output ready);
endinterface

// File: rtl/udma_rx_packer.sv
// Packs a peripheral byte stream little-endian into 32-bit uDMA RX beats and drains
// partial words on flush. Optional idle auto-flush: define UDMA_RX_PACKER_TIMEOUT_EN.
module udma_rx_packer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  input  logic                 flush_i,
`ifdef UDMA_RX_PACKER_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0] timeout_cfg_i,
`endif
  udma_rx_packer_if.master     rx,
  output logic [1:0]           pending_o,
  output logic                 flush_done_o
);

  typedef enum logic [1:0] {S_FILL, S_FLUSH, S_DONE} state_t;

  state_t      state_q;
  logic [23:0] acc_q;
  logic [1:0]  cnt_q;
  logic        valid_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;

  logic load_ok;
  logic byte_acc;
  logic flush_req;
  logic timeout_hit;

  // The output register may be refilled whenever it is empty or being drained this cycle.
  assign load_ok      = !valid_q || rx.ready;
  assign byte_ready_o = (state_q == S_FILL) && ((cnt_q != 2'd3) || load_ok);
  assign byte_acc     = byte_valid_i && byte_ready_o;
  assign flush_req    = flush_i || timeout_hit;

  assign rx.valid     = valid_q;
  assign rx.data      = data_q;
  assign rx.datasize  = size_q;
  assign pending_o    = cnt_q;
  assign flush_done_o = (state_q == S_DONE);

`ifdef UDMA_RX_PACKER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] idle_q;

  // Counter parks at the threshold; leaving FILL clears it, so it fires once per idle period.
  assign timeout_hit = (timeout_cfg_i != '0) && (idle_q == timeout_cfg_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q <= '0;
    end else if (clr_i || byte_acc || (cnt_q == 2'd0) || (state_q != S_FILL)) begin
      idle_q <= '0;
    end else if ((idle_q != timeout_cfg_i) && (idle_q != '1)) begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: state is written only with non-blocking assignments so every read in this
  // block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      size_q  <= '0;
    end else if (clr_i) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && rx.ready) valid_q <= 1'b0;

      unique case (state_q)
        S_FILL: begin
          if (byte_acc) begin
            unique case (cnt_q)
              2'd0: acc_q[7:0]   <= byte_data_i;
              2'd1: acc_q[15:8]  <= byte_data_i;
              2'd2: acc_q[23:16] <= byte_data_i;
              2'd3: begin
                data_q  <= {byte_data_i, acc_q};
                size_q  <= 2'd2;
                valid_q <= 1'b1;
              end
            endcase
            cnt_q <= cnt_q + 2'd1;  // 3 wraps to 0 when the word is emitted
          end
          if (flush_req) state_q <= S_FLUSH;
        end

        S_FLUSH: begin
          if (load_ok) begin
            unique case (cnt_q)
              2'd3: begin
                data_q     <= {16'h0, acc_q[15:0]};
                size_q     <= 2'd1;
                valid_q    <= 1'b1;
                acc_q[7:0] <= acc_q[23:16];
                cnt_q      <= 2'd1;
              end
              2'd2: begin
                data_q  <= {16'h0, acc_q[15:0]};
                size_q  <= 2'd1;
                valid_q <= 1'b1;
                cnt_q   <= 2'd0;
              end
              2'd1: begin
                data_q  <= {24'h0, acc_q[7:0]};
                size_q  <= 2'd0;
                valid_q <= 1'b1;
                cnt_q   <= 2'd0;
              end
              2'd0: state_q <= S_DONE;
            endcase
          end
        end

        S_DONE: state_q <= S_FILL;

        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_rx_packer.sv
// Self-checking bench for udma_rx_packer: cycle vector table plus hand sequences,
// with a beat scoreboard fed at stimulus time and drained by a negedge monitor.
module tb_udma_rx_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready;
  logic       flush = 1'b0;
  logic [1:0] pending;
  logic       flush_done;
`ifdef UDMA_RX_PACKER_TIMEOUT_EN
  logic [15:0] timeout_cfg = 16'd0;
`endif

  udma_rx_packer_if rx_if ();

  udma_rx_packer #(.TIMEOUT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .flush_i      (flush),
`ifdef UDMA_RX_PACKER_TIMEOUT_EN
    .timeout_cfg_i(timeout_cfg),
`endif
    .rx           (rx_if.master),
    .pending_o    (pending),
    .flush_done_o (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  size;
  } beat_t;

  typedef struct {
    logic        bv;
    logic [7:0]  bd;
    logic        fl;
    logic        rdy;
    logic        exp_br;
    logic [1:0]  exp_pend;
    logic        exp_valid;
    logic        exp_done;
    logic        push;
    logic [31:0] pdata;
    logic [1:0]  psize;
  } vec_t;

  beat_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [1:0] s);
    beat_t b;
    b.data = d;
    b.size = s;
    sb_q.push_back(b);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        next_cycle();
        byte_valid = 1'b0;
        return;
      end
    end
    check("byte_accept_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0;
  endtask

  // Scoreboard monitor and hold-stability check, sampled on the falling edge.
  logic        prev_hold = 1'b0;
  logic        prev_clr  = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_size = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold && !prev_clr) begin
        check("hold_valid", {31'd0, rx_if.valid}, 32'd1);
        check("hold_data", rx_if.data, prev_data);
        check("hold_size", {30'd0, rx_if.datasize}, {30'd0, prev_size});
      end
      if (rx_if.valid && rx_if.ready && !clr) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h, expected no beat (t=%0t)", rx_if.data, $time);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          check("beat_data", rx_if.data, e.data);
          check("beat_size", {30'd0, rx_if.datasize}, {30'd0, e.size});
        end
      end
      prev_hold = rx_if.valid && !rx_if.ready;
      prev_clr  = clr;
      prev_data = rx_if.data;
      prev_size = rx_if.datasize;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[12];
  int   done_cnt;
  int   n;

  initial begin
    //        bv  bd     fl  rdy br  pend val done push data          size
    vecs[0]  = '{0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 0, 32'h0,        2'd0};
    vecs[1]  = '{1, 8'h11, 0, 1, 1, 2'd0, 0, 0, 0, 32'h0,        2'd0};
    vecs[2]  = '{1, 8'h22, 0, 1, 1, 2'd1, 0, 0, 0, 32'h0,        2'd0};
    vecs[3]  = '{1, 8'h33, 0, 1, 1, 2'd2, 0, 0, 0, 32'h0,        2'd0};
    vecs[4]  = '{1, 8'h44, 0, 1, 1, 2'd3, 0, 0, 1, 32'h44332211, 2'd2};
    vecs[5]  = '{0, 8'h00, 0, 1, 1, 2'd0, 1, 0, 0, 32'h0,        2'd0};
    vecs[6]  = '{0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 0, 32'h0,        2'd0};
    // empty flush: request at t, FLUSH at t+1, done at t+2, FILL at t+3
    vecs[7]  = '{0, 8'h00, 1, 1, 1, 2'd0, 0, 0, 0, 32'h0,        2'd0};
    vecs[8]  = '{0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 0, 32'h0,        2'd0};
    vecs[9]  = '{0, 8'h00, 0, 1, 0, 2'd0, 0, 1, 0, 32'h0,        2'd0};
    vecs[10] = '{0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 0, 32'h0,        2'd0};
    vecs[11] = '{0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 0, 32'h0,        2'd0};

    rx_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, rx_if.valid}, 32'd0);
    check("rst_data", rx_if.data, 32'd0);
    check("rst_size", {30'd0, rx_if.datasize}, 32'd0);
    check("rst_pending", {30'd0, pending}, 32'd0);
    check("rst_done", {31'd0, flush_done}, 32'd0);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
    next_cycle();
    rst = 1'b0;

    // Table: back-to-back word, then empty flush timing.
    for (int i = 0; i < 12; i++) begin
      byte_valid  = vecs[i].bv;
      byte_data   = vecs[i].bd;
      flush       = vecs[i].fl;
      rx_if.ready = vecs[i].rdy;
      if (vecs[i].push) push_beat(vecs[i].pdata, vecs[i].psize);
      @(negedge clk);
      check($sformatf("vec%0d_byte_ready", i), {31'd0, byte_ready}, {31'd0, vecs[i].exp_br});
      check($sformatf("vec%0d_pending", i), {30'd0, pending}, {30'd0, vecs[i].exp_pend});
      check($sformatf("vec%0d_valid", i), {31'd0, rx_if.valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_done", i), {31'd0, flush_done}, {31'd0, vecs[i].exp_done});
      next_cycle();
    end
    byte_valid = 1'b0;
    flush      = 1'b0;
    check("sb_empty_table", sb_q.size(), 32'd0);

    // Backpressure: 8 bytes with ready low, then release without a bubble.
    rx_if.ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      logic [7:0] b;
      b = 8'(8'h11 * (i + 1));
      if (i == 3) push_beat(32'h44332211, 2'd2);
      send_byte(b);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h88;
    push_beat(32'h88776655, 2'd2);
    @(negedge clk);
    check("bp_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("bp_pending", {30'd0, pending}, 32'd3);
    check("bp_held_data", rx_if.data, 32'h44332211);
    next_cycle();
    @(negedge clk);
    check("bp_held_again", rx_if.data, 32'h44332211);
    next_cycle();
    rx_if.ready = 1'b1;
    @(negedge clk);
    check("bp_release_byte_ready", {31'd0, byte_ready}, 32'd1);
    next_cycle();
    byte_valid = 1'b0;
    @(negedge clk);
    check("bp_no_bubble_valid", {31'd0, rx_if.valid}, 32'd1);
    check("bp_no_bubble_data", rx_if.data, 32'h88776655);
    check("bp_pending_after", {30'd0, pending}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("sb_empty_bp", sb_q.size(), 32'd0);
    next_cycle();

    // Flush of three pending bytes: halfword then byte, then one done pulse.
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    push_beat(32'h0000BBAA, 2'd1);
    push_beat(32'h000000CC, 2'd0);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    done_cnt = 0;
    for (int i = 0; i < 20 && done_cnt == 0; i++) begin
      @(negedge clk);
      check("flush_byte_ready", {31'd0, byte_ready}, 32'd0);
      if (flush_done) done_cnt++;
      next_cycle();
    end
    byte_valid = 1'b0;
    check("flush_done_seen", done_cnt, 32'd1);
    @(negedge clk);
    check("flush_done_single", {31'd0, flush_done}, 32'd0);
    check("flush_back_to_fill", {31'd0, byte_ready}, 32'd1);
    check("flush_pending", {30'd0, pending}, 32'd0);
    check("sb_empty_flush", sb_q.size(), 32'd0);
    next_cycle();

    // Clear with two pending bytes and a held word.
    rx_if.ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    @(negedge clk);
    check("clr_pre_pending", {30'd0, pending}, 32'd2);
    check("clr_pre_valid", {31'd0, rx_if.valid}, 32'd1);
    next_cycle();
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
    @(negedge clk);
    check("clr_valid", {31'd0, rx_if.valid}, 32'd0);
    check("clr_pending", {30'd0, pending}, 32'd0);
    check("clr_byte_ready", {31'd0, byte_ready}, 32'd1);
    next_cycle();
    rx_if.ready = 1'b1;

`ifdef UDMA_RX_PACKER_TIMEOUT_EN
    // Idle timeout flush of a single byte.
    timeout_cfg = 16'd5;
    push_beat(32'h0000005A, 2'd0);
    send_byte(8'h5A);
    n = 0;
    for (int i = 0; i < 40 && !rx_if.valid; i++) begin
      @(negedge clk);
      n++;
      if (!rx_if.valid) next_cycle();
    end
    check("to_beat_seen", {31'd0, rx_if.valid}, 32'd1);
    check("to_after_idle", {31'd0, n > 5}, 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 20 && done_cnt == 0; i++) begin
      next_cycle();
      @(negedge clk);
      if (flush_done) done_cnt++;
    end
    check("to_done", done_cnt, 32'd1);
    next_cycle();
    check("sb_empty_to", sb_q.size(), 32'd0);

    // Timeout disabled: the byte stays pending.
    timeout_cfg = 16'd0;
    send_byte(8'h77);
    repeat (100) next_cycle();
    @(negedge clk);
    check("to_off_valid", {31'd0, rx_if.valid}, 32'd0);
    check("to_off_pending", {30'd0, pending}, 32'd1);
    next_cycle();
    push_beat(32'h00000077, 2'd0);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    repeat (6) next_cycle();
    check("sb_empty_to_off", sb_q.size(), 32'd0);
`endif

    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
